// File: rtl/spi_master_pkg.sv
// spi_master_pkg: register map, status/control bit indices and FSM states of the SPI master
package spi_master_pkg;
  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_CLKDIV = 3'd4;
  localparam logic [2:0] ADDR_SLAVE = 3'd5;
  localparam logic [2:0] ADDR_LEVELS = 3'd6;
  localparam int ST_TMT = 0;
  localparam int ST_TRDY = 1;
  localparam int ST_RRDY = 2;
  localparam int ST_TOE = 3;
  localparam int ST_ROE = 4;
  localparam int ST_BUSY = 5;
  localparam int CTL_CPOL = 8;
  localparam int CTL_CPHA = 9;
  localparam int CTL_LSB = 10;
  localparam int CTL_SSO = 11;
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous FIFO with simultaneous push/pop in every fill state
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && (!empty || push);
  assign dout = empty ? din : mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with runtime mode, clock divider, slave selects and TX/RX FIFOs
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_select,
  input  logic [2:0]            mem_addr,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           data_from_cpu,
  output logic [31:0]           data_to_cpu,
  output logic                  irq,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] SS_n
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $clog2(2 * DATA_WIDTH);
  state_t state_q, state_d;
  logic [11:0] control;
  logic [DIV_WIDTH-1:0] clkdiv, h_div, div_cnt;
  logic [NUM_SLAVES-1:0] ss_reg, ss_l;
  logic [DATA_WIDTH-1:0] shreg, rxreg, sh_next, tx_dout, rx_dout;
  logic [EW-1:0] edge_cnt, k;
  logic [CW-1:0] tx_count, rx_count;
  logic [5:0] status;
  logic [31:0] rd_val;
  logic toe, roe, cpol_l, cpha_l, lsb_l;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr, rd, wr_status, tx_push, rx_pop, load, rx_push;
  logic tick, last, edge_ev, do_sample, do_shift;
  assign wr = spi_select && !write_n;
  assign rd = spi_select && !read_n;
  assign wr_status = wr && mem_addr == ADDR_STATUS;
  assign tx_push = wr && mem_addr == ADDR_TXDATA;
  assign rx_pop = rd && mem_addr == ADDR_RXDATA && !rx_empty;
  assign tick = div_cnt == '0;
  assign last = edge_cnt == EW'(2 * DATA_WIDTH - 1);
  assign edge_ev = tick && (state_q == LEAD || (state_q == SHIFT && !last));
  assign k = state_q == LEAD ? '0 : edge_cnt + 1'b1;
  assign do_sample = edge_ev && (k[0] == cpha_l);
  assign do_shift = edge_ev && (k[0] != cpha_l) && (cpha_l ? k != '0 : k != EW'(2 * DATA_WIDTH - 1));
  assign sh_next = lsb_l ? shreg >> 1 : shreg << 1;
  assign SS_n = state_q != IDLE ? ~ss_l : control[CTL_SSO] ? ~ss_reg : '1;
  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push(tx_push), .pop(load), .din(data_from_cpu[DATA_WIDTH-1:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rxreg),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    status = '0;
    status[ST_TMT] = state_q == IDLE && tx_empty;
    status[ST_TRDY] = !tx_full;
    status[ST_RRDY] = !rx_empty;
    status[ST_TOE] = toe;
    status[ST_ROE] = roe;
    status[ST_BUSY] = state_q != IDLE;
  end
  always_comb
    rd_val = mem_addr == ADDR_RXDATA  ? (rx_empty ? 32'b0 : 32'(rx_dout)) :
             mem_addr == ADDR_STATUS  ? 32'(status) :
             mem_addr == ADDR_CONTROL ? 32'(control) :
             mem_addr == ADDR_CLKDIV  ? 32'(clkdiv) :
             mem_addr == ADDR_SLAVE   ? 32'(ss_reg) :
             mem_addr == ADDR_LEVELS  ? {16'b0, 8'(rx_count), 8'(tx_count)} : 32'b0;
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      IDLE: begin
        load = !tx_empty;
        state_d = tx_empty ? IDLE : LEAD;
      end
      LEAD: state_d = tick ? SHIFT : LEAD;
      SHIFT: state_d = tick && last ? TRAIL : SHIFT;
      default: begin
        rx_push = tick;
        load = tick && !tx_empty;
        state_d = !tick ? TRAIL : tx_empty ? IDLE : LEAD;
      end
    endcase
  end
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      control <= '0;
      clkdiv <= '0;
      ss_reg <= NUM_SLAVES'(1);
      toe <= 1'b0;
      roe <= 1'b0;
      irq <= 1'b0;
      data_to_cpu <= '0;
      h_div <= '0;
      div_cnt <= '0;
      ss_l <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      shreg <= '0;
      rxreg <= '0;
      edge_cnt <= '0;
      SCLK <= 1'b0;
      MOSI <= 1'b0;
    end else begin
      if (wr && mem_addr == ADDR_CONTROL) control <= data_from_cpu[11:0];
      if (wr && mem_addr == ADDR_CLKDIV) clkdiv <= data_from_cpu[DIV_WIDTH-1:0];
      if (wr && mem_addr == ADDR_SLAVE) ss_reg <= data_from_cpu[NUM_SLAVES-1:0];
      toe <= (tx_push && tx_full && !load) || (toe && !wr_status);
      roe <= (rx_push && rx_full && !rx_pop) || (roe && !wr_status);
      irq <= |(status[4:0] & control[4:0]);
      if (rd) data_to_cpu <= rd_val;
      if (load) begin
        h_div <= clkdiv;
        ss_l <= ss_reg;
        cpol_l <= control[CTL_CPOL];
        cpha_l <= control[CTL_CPHA];
        lsb_l <= control[CTL_LSB];
        shreg <= tx_dout;
        MOSI <= control[CTL_LSB] ? tx_dout[0] : tx_dout[DATA_WIDTH-1];
      end else if (do_shift) begin
        shreg <= sh_next;
        MOSI <= lsb_l ? sh_next[0] : sh_next[DATA_WIDTH-1];
      end
      div_cnt <= load ? clkdiv : state_q == IDLE ? div_cnt : tick ? h_div : div_cnt - 1'b1;
      if (edge_ev) edge_cnt <= k;
      if (do_sample) rxreg <= lsb_l ? (rxreg >> 1) | (DATA_WIDTH'(MISO) << (DATA_WIDTH - 1)) : (rxreg << 1) | DATA_WIDTH'(MISO);
      SCLK <= (load || state_q == IDLE) ? control[CTL_CPOL] : edge_ev ? ~SCLK : SCLK;
    end
  end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed self-checking bench for spi_master_fifo
module tb_spi_master_fifo;
  logic clk = 1'b0, reset = 1'b1, sel0 = 1'b0, sel1 = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0] mem_addr = '0;
  logic [31:0] data_from_cpu = '0, dout0, dout1;
  logic irq0, irq1, mosi0, mosi1, sclk0, sclk1, miso0;
  logic [0:0] ss0;
  logic [3:0] ss1;
  logic loop0 = 1'b1, cpol_t = 1'b0, cpha_t = 1'b0, sl_miso = 1'b0;
  logic [7:0] sl_tx = 8'hC3, mosi_bits0 = '0;
  logic [15:0] seq1 = '0;
  logic [3:0] ss_seen1 = 4'hF;
  int sl_idx = 0, pass_cnt = 0, total = 0, rise_cnt = 0, ss_low_cyc0 = 0, edges0 = 0, hp_bad = 0, n1 = 0, ss_bad1 = 0;
  time last_t = 0;
  assign miso0 = loop0 ? mosi0 : sl_miso;
  spi_master_fifo #(.DATA_WIDTH(8), .NUM_SLAVES(1), .FIFO_DEPTH(4), .DIV_WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .spi_select(sel0), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(dout0), .irq(irq0), .MISO(miso0), .MOSI(mosi0), .SCLK(sclk0), .SS_n(ss0)
  );
  spi_master_fifo #(.DATA_WIDTH(16), .NUM_SLAVES(4), .FIFO_DEPTH(4), .DIV_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .spi_select(sel1), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(dout1), .irq(irq1), .MISO(mosi1), .MOSI(mosi1), .SCLK(sclk1), .SS_n(ss1)
  );
  always #5 clk = ~clk;
  always @(posedge sclk0) if (!ss0[0]) begin rise_cnt++; mosi_bits0 = {mosi_bits0[6:0], mosi0}; end
  always @(sclk0) if (!ss0[0]) begin if (edges0 > 0 && $time - last_t != 40) hp_bad++; last_t = $time; edges0++; end
  always @(negedge clk) begin
    if (!ss0[0]) ss_low_cyc0++;
    if (ss1 != 4'hF) begin if (ss1 != 4'b1011) ss_bad1++; ss_seen1 = ss1; end
  end
  always @(posedge sclk1) if (ss1 != 4'hF) begin if (n1 < 16) seq1[n1] = mosi1; n1++; end
  always @(negedge ss0[0]) begin sl_idx = 0; if (!cpha_t) begin sl_miso = sl_tx[7]; sl_idx = 1; end end
  always @(sclk0) if (!ss0[0] && ((sclk0 != cpol_t) == cpha_t) && sl_idx < 8) begin sl_miso = sl_tx[7 - sl_idx]; sl_idx++; end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic cpu_write(input int dut, input logic [2:0] a, input logic [31:0] d);
    sel0 = dut == 0; sel1 = dut == 1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1; sel0 = 1'b0; sel1 = 1'b0;
  endtask
  task automatic cpu_read(input int dut, input logic [2:0] a, output logic [31:0] d);
    sel0 = dut == 0; sel1 = dut == 1; mem_addr = a; read_n = 1'b0;
    @(negedge clk);
    read_n = 1'b1; sel0 = 1'b0; sel1 = 1'b0;
    d = dut == 0 ? dout0 : dout1;
  endtask
  task automatic wait_idle(input int dut, input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    do begin cpu_read(dut, 3'd2, s); n++; end while (!s[0] && n < budget);
    total++; if (!s[0]) $display("FAIL wait_idle dut%0d: got status %h want TMT set", dut, s); else pass_cnt++;
  endtask
  task automatic test_reset;
    logic [31:0] r;
    total++; if (dout0 !== 32'h0) $display("FAIL reset_dout: got %h want 0", dout0); else pass_cnt++;
    total++; if ({irq0, ss0, sclk0, mosi0} !== 4'b0100) $display("FAIL reset_pins: got %b want 0100", {irq0, ss0, sclk0, mosi0}); else pass_cnt++;
    total++; if (ss1 !== 4'hF) $display("FAIL reset_ss1: got %b want 1111", ss1); else pass_cnt++;
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h3) $display("FAIL reset_status: got %h want 3", r); else pass_cnt++;
    cpu_read(0, 3'd6, r);
    total++; if (r !== 32'h0) $display("FAIL reset_levels: got %h want 0", r); else pass_cnt++;
    cpu_read(0, 3'd5, r);
    total++; if (r !== 32'h1) $display("FAIL reset_slave: got %h want 1", r); else pass_cnt++;
    cpu_read(0, 3'd3, r);
    total++; if (r !== 32'h0) $display("FAIL reset_control: got %h want 0", r); else pass_cnt++;
    cpu_read(0, 3'd0, r);
    total++; if (r !== 32'h0) $display("FAIL reset_rx_empty: got %h want 0", r); else pass_cnt++;
    cpu_write(0, 3'd4, 32'h5);
    cpu_read(0, 3'd7, r);
    total++; if (r !== 32'h0) $display("FAIL addr7: got %h want 0", r); else pass_cnt++;
    cpu_read(0, 3'd4, r);
    total++; if (r !== 32'h5) $display("FAIL clkdiv_rw: got %h want 5", r); else pass_cnt++;
    cpu_write(0, 3'd4, 32'h0);
  endtask
  task automatic test_mode0_loop;
    logic [31:0] r;
    loop0 = 1'b1; rise_cnt = 0; mosi_bits0 = '0; ss_low_cyc0 = 0;
    cpu_write(0, 3'd1, 32'hA5);
    wait_idle(0, 200);
    total++; if (rise_cnt !== 8) $display("FAIL m0_rises: got %0d want 8", rise_cnt); else pass_cnt++;
    total++; if (mosi_bits0 !== 8'hA5) $display("FAIL m0_mosi: got %h want a5", mosi_bits0); else pass_cnt++;
    total++; if (ss_low_cyc0 !== 18) $display("FAIL m0_ss_cycles: got %0d want 18", ss_low_cyc0); else pass_cnt++;
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h7) $display("FAIL m0_status: got %h want 7", r); else pass_cnt++;
    cpu_read(0, 3'd0, r);
    total++; if (r !== 32'hA5) $display("FAIL m0_rxdata: got %h want a5", r); else pass_cnt++;
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h3) $display("FAIL m0_status_after: got %h want 3", r); else pass_cnt++;
  endtask
  task automatic test_modes;
    logic [31:0] r;
    loop0 = 1'b0; sl_tx = 8'hC3;
    cpu_write(0, 3'd4, 32'h3);
    for (int m = 0; m < 4; m++) begin
      cpol_t = m[0]; cpha_t = m[1];
      cpu_write(0, 3'd3, {22'b0, cpha_t, cpol_t, 8'b0});
      @(negedge clk);
      total++; if (sclk0 !== cpol_t) $display("FAIL mode%0d_idle_sclk: got %b want %b", m, sclk0, cpol_t); else pass_cnt++;
      edges0 = 0; hp_bad = 0;
      cpu_write(0, 3'd1, 32'h3C);
      wait_idle(0, 500);
      cpu_read(0, 3'd0, r);
      total++; if (r !== 32'hC3) $display("FAIL mode%0d_rxdata: got %h want c3", m, r); else pass_cnt++;
      total++; if (edges0 !== 16 || hp_bad !== 0) $display("FAIL mode%0d_sclk: got %0d edges %0d bad want 16 0", m, edges0, hp_bad); else pass_cnt++;
      total++; if (sclk0 !== cpol_t) $display("FAIL mode%0d_end_sclk: got %b want %b", m, sclk0, cpol_t); else pass_cnt++;
    end
    loop0 = 1'b1;
    cpu_write(0, 3'd3, 32'h0);
  endtask
  task automatic test_overflow;
    logic [31:0] r;
    logic [31:0] exp_rx [5];
    exp_rx = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
    for (int i = 1; i <= 6; i++) cpu_write(0, 3'd1, 32'(i * 32'h11));
    cpu_read(0, 3'd6, r);
    total++; if (r !== 32'h4) $display("FAIL tx_levels: got %h want 4", r); else pass_cnt++;
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h28) $display("FAIL toe_status: got %h want 28", r); else pass_cnt++;
    cpu_write(0, 3'd2, 32'h0);
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h20) $display("FAIL toe_clear: got %h want 20", r); else pass_cnt++;
    wait_idle(0, 1000);
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h17) $display("FAIL roe_status: got %h want 17", r); else pass_cnt++;
    cpu_read(0, 3'd6, r);
    total++; if (r !== 32'h400) $display("FAIL rx_levels: got %h want 400", r); else pass_cnt++;
    total++; if (irq0 !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq0); else pass_cnt++;
    cpu_write(0, 3'd3, 32'h10);
    @(negedge clk);
    total++; if (irq0 !== 1'b1) $display("FAIL irq_roe: got %b want 1", irq0); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cpu_read(0, 3'd0, r);
      total++; if (r !== exp_rx[i]) $display("FAIL rx_read%0d: got %h want %h", i, r, exp_rx[i]); else pass_cnt++;
    end
    cpu_write(0, 3'd2, 32'h0);
    @(negedge clk);
    total++; if (irq0 !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq0); else pass_cnt++;
    cpu_write(0, 3'd3, 32'h0);
  endtask
  task automatic test_lsb16;
    logic [31:0] r;
    cpu_write(1, 3'd5, 32'h4);
    cpu_write(1, 3'd3, 32'h400);
    n1 = 0; seq1 = '0; ss_bad1 = 0; ss_seen1 = 4'hF;
    cpu_write(1, 3'd1, 32'h8001);
    wait_idle(1, 300);
    total++; if (n1 !== 16) $display("FAIL lsb_rises: got %0d want 16", n1); else pass_cnt++;
    total++; if ({seq1[0], seq1[14], seq1[15]} !== 3'b101) $display("FAIL lsb_bits: got %b want 101", {seq1[0], seq1[14], seq1[15]}); else pass_cnt++;
    total++; if (ss_seen1 !== 4'b1011 || ss_bad1 !== 0) $display("FAIL lsb_ss: got %b bad %0d want 1011 0", ss_seen1, ss_bad1); else pass_cnt++;
    cpu_read(1, 3'd0, r);
    total++; if (r !== 32'h8001) $display("FAIL lsb_rxdata: got %h want 8001", r); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    logic [31:0] r;
    cpu_write(0, 3'd4, 32'h3);
    rise_cnt = 0;
    cpu_write(0, 3'd1, 32'h5A);
    cpu_write(0, 3'd1, 32'h77);
    for (int i = 0; i < 300 && rise_cnt < 4; i++) @(negedge clk);
    total++; if (rise_cnt !== 4) $display("FAIL mid_reach: got %0d want 4", rise_cnt); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({ss0, sclk0, irq0, mosi0} !== 4'b1000) $display("FAIL mid_pins: got %b want 1000", {ss0, sclk0, irq0, mosi0}); else pass_cnt++;
    repeat (3) @(negedge clk);
    total++; if (ss0 !== 1'b1) $display("FAIL mid_idle_ss: got %b want 1", ss0); else pass_cnt++;
    cpu_read(0, 3'd6, r);
    total++; if (r !== 32'h0) $display("FAIL mid_levels: got %h want 0", r); else pass_cnt++;
    cpu_read(0, 3'd2, r);
    total++; if (r !== 32'h3) $display("FAIL mid_status: got %h want 3", r); else pass_cnt++;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_mode0_loop;
    test_modes;
    test_overflow;
    test_lsb16;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
